// File: rtl/dcpu2_pkg.sv
// Shared types and constants for the dcpu2 execution core.
// Instruction classes are decoded from the top five opcode bits.
package dcpu2_pkg;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_INT
    } state_t;

    typedef enum logic [3:0] {
        OP_LDI,
        OP_LDH,
        OP_LD,
        OP_ST,
        OP_ALU,
        OP_JMP,
        OP_CALL,
        OP_RET,
        OP_NOP
    } opclass_t;

    localparam logic [3:0] ALU_MOV = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_SHL = 4'd6;
    localparam logic [3:0] ALU_SHR = 4'd7;
    localparam logic [3:0] ALU_CMP = 4'd8;

    localparam logic [2:0] COND_AL = 3'd0;
    localparam logic [2:0] COND_C  = 3'd1;
    localparam logic [2:0] COND_Z  = 3'd2;
    localparam logic [2:0] COND_NC = 3'd3;
    localparam logic [2:0] COND_NZ = 3'd4;

    localparam int ST_C  = 0;
    localparam int ST_Z  = 1;
    localparam int ST_IE = 2;

    localparam logic [3:0] REG_ST = 4'd13;
    localparam logic [3:0] REG_SP = 4'd14;
    localparam logic [3:0] REG_PC = 4'd15;

    function automatic opclass_t op_class(input logic [4:0] top);
        opclass_t cls;
        casez (top)
            5'b00???: cls = OP_LDI;
            5'b01???: cls = OP_LDH;
            5'b100??: cls = OP_LD;
            5'b101??: cls = OP_ST;
            5'b1100?: cls = OP_ALU;
            5'b11010: cls = OP_JMP;
            5'b11011: cls = OP_CALL;
            5'b1110?: cls = OP_RET;
            default:  cls = OP_NOP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/dcpu2_alu.sv
// Combinational ALU: result, carry/borrow and zero, plus which of them the op commits.
// cmp computes the subtraction so Z is valid, but never writes the result back.
module dcpu2_alu
    import dcpu2_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result,
    output logic        c,
    output logic        z,
    output logic        wr_result,
    output logic        wr_flags
);

    always_comb begin
        result    = '0;
        c         = 1'b0;
        wr_result = 1'b0;
        wr_flags  = 1'b0;
        case (op)
            ALU_MOV: begin result = b; wr_result = 1'b1; end
            ALU_ADD: begin {c, result} = {1'b0, a} + {1'b0, b}; wr_result = 1'b1; wr_flags = 1'b1; end
            ALU_SUB: begin {c, result} = {1'b0, a} - {1'b0, b}; wr_result = 1'b1; wr_flags = 1'b1; end
            ALU_AND: begin result = a & b; wr_result = 1'b1; wr_flags = 1'b1; end
            ALU_OR:  begin result = a | b; wr_result = 1'b1; wr_flags = 1'b1; end
            ALU_XOR: begin result = a ^ b; wr_result = 1'b1; wr_flags = 1'b1; end
            ALU_SHL: begin result = {a[14:0], 1'b0}; c = a[15]; wr_result = 1'b1; wr_flags = 1'b1; end
            ALU_SHR: begin result = {1'b0, a[15:1]}; c = a[0]; wr_result = 1'b1; wr_flags = 1'b1; end
            ALU_CMP: begin {c, result} = {1'b0, a} - {1'b0, b}; wr_flags = 1'b1; end
            default: ;
        endcase
    end

    assign z = (result == 16'h0000);

endmodule

// File: rtl/dcpu2_core.sv
// dcpu2 execution core: register file, sequencing FSM and the shared request/ack bus.
// state   | meaning
// FETCH   | read instruction at PC, PC+1 on ack
// EXEC    | finish single-cycle ops, or hand off to MEM
// MEM     | one data access (ld/st/call push/ret pop)
// INT     | push PC, clear IE, vector to INT_VEC
module dcpu2_core
    import dcpu2_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] INT_VEC  = 16'h0008,
    parameter logic [15:0] SP_INIT  = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_dat,
    output logic [15:0] o_dat,
    output logic [15:0] o_addr,
    output logic        o_we,
    output logic        o_cs,
    input  logic        i_ack,
    input  logic        i_int
);

    state_t      state, state_nxt;
    opclass_t    cls;
    logic [15:0] op, op_nxt;
    logic [15:0] regs     [16];
    logic [15:0] regs_nxt [16];
    logic [3:0]  dst, src;
    logic [15:0] rd_dst, rd_src, st, sp, pc, ea;
    logic [15:0] alu_result;
    logic        alu_c, alu_z, alu_wr_result, alu_wr_flags;
    logic        cond_ok, ack, done;

    assign cls    = op_class(op[15:11]);
    assign dst    = op[3:0];
    assign src    = op[7:4];
    assign rd_dst = regs[dst];
    assign rd_src = regs[src];
    assign st     = regs[REG_ST];
    assign sp     = regs[REG_SP];
    assign pc     = regs[REG_PC];
    assign ea     = rd_src + {{11{op[12]}}, op[12:8]};
    assign ack    = i_ack && o_cs;

    dcpu2_alu u_alu (
        .op        (op[11:8]),
        .a         (rd_dst),
        .b         (rd_src),
        .result    (alu_result),
        .c         (alu_c),
        .z         (alu_z),
        .wr_result (alu_wr_result),
        .wr_flags  (alu_wr_flags)
    );

    always_comb begin
        case (op[10:8])
            COND_AL: cond_ok = 1'b1;
            COND_C:  cond_ok = st[ST_C];
            COND_Z:  cond_ok = st[ST_Z];
            COND_NC: cond_ok = !st[ST_C];
            COND_NZ: cond_ok = !st[ST_Z];
            default: cond_ok = 1'b0;
        endcase
    end

    // Bus outputs depend only on registered state, so they hold steady across wait cycles.
    always_comb begin
        o_cs   = 1'b0;
        o_we   = 1'b0;
        o_addr = '0;
        o_dat  = '0;
        case (state)
            S_FETCH: begin o_cs = 1'b1; o_addr = pc; end
            S_MEM: begin
                o_cs = 1'b1;
                case (cls)
                    OP_ST:   begin o_addr = ea; o_we = 1'b1; o_dat = rd_dst; end
                    OP_CALL: begin o_addr = sp - 16'd1; o_we = 1'b1; o_dat = pc; end
                    OP_RET:  o_addr = sp;
                    default: o_addr = ea;
                endcase
            end
            S_INT: begin o_cs = 1'b1; o_we = 1'b1; o_addr = sp - 16'd1; o_dat = pc; end
            default: ;
        endcase
        if (i_reset) begin
            o_cs   = 1'b0;
            o_we   = 1'b0;
            o_addr = '0;
            o_dat  = '0;
        end
    end

    always_comb begin
        state_nxt = state;
        op_nxt    = op;
        regs_nxt  = regs;
        done      = 1'b0;
        case (state)
            S_FETCH: if (ack) begin
                op_nxt           = i_dat;
                regs_nxt[REG_PC] = pc + 16'd1;
                state_nxt        = S_EXEC;
            end
            S_EXEC: begin
                done = 1'b1;
                case (cls)
                    OP_LDI: regs_nxt[dst] = {6'h00, op[13:4]};
                    OP_LDH: regs_nxt[dst] = {op[11:4], rd_dst[7:0]};
                    OP_ALU: begin
                        // flags first so an explicit write to ST overrides them
                        if (alu_wr_flags) begin
                            regs_nxt[REG_ST][ST_C] = alu_c;
                            regs_nxt[REG_ST][ST_Z] = alu_z;
                        end
                        if (alu_wr_result) regs_nxt[dst] = alu_result;
                    end
                    OP_JMP: if (cond_ok) regs_nxt[REG_PC] = rd_dst;
                    OP_NOP: ;
                    default: begin done = 1'b0; state_nxt = S_MEM; end
                endcase
            end
            S_MEM: if (ack) begin
                done = 1'b1;
                case (cls)
                    OP_LD: regs_nxt[dst] = i_dat;
                    OP_CALL: begin
                        regs_nxt[REG_SP] = sp - 16'd1;
                        regs_nxt[REG_PC] = rd_dst;
                    end
                    OP_RET: begin
                        regs_nxt[REG_SP] = sp + 16'd1;
                        regs_nxt[REG_PC] = i_dat;
                        if (op[0]) regs_nxt[REG_ST][ST_IE] = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_INT: if (ack) begin
                regs_nxt[REG_SP]        = sp - 16'd1;
                regs_nxt[REG_ST][ST_IE] = 1'b0;
                regs_nxt[REG_PC]        = INT_VEC;
                state_nxt               = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
        // IE as it stood before this instruction, so reti's successor always runs
        if (done) state_nxt = (i_int && st[ST_IE]) ? S_INT : S_FETCH;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= S_FETCH;
            op             <= '0;
            regs[REG_ST]   <= '0;
            regs[REG_SP]   <= SP_INIT;
            regs[REG_PC]   <= RESET_PC;
        end else begin
            state <= state_nxt;
            op    <= op_nxt;
            for (int i = 0; i < 16; i++) regs[i] <= regs_nxt[i];
        end
    end

endmodule
